// File: rtl/deinterleaver.sv
// 802.11a receive bit deinterleaver: ping-pong symbol banks, one bit in and one bit out per clock.
// Optional symbolEnd output enabled by defining DEINTERLEAVER_SYMBOL_END_EN.
module deinterleaver #(
  parameter int MAX_NCBPS = 288
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inputData,
  input  logic       inputValid,
  input  logic [1:0] mode,
  output logic       outputData,
`ifdef DEINTERLEAVER_SYMBOL_END_EN
  output logic       symbolEnd,
`endif
  output logic       outputValid
);

  function automatic logic [8:0] ncbps_m1(input logic [1:0] m);
    case (m)
      2'd0:    ncbps_m1 = 9'd47;
      2'd1:    ncbps_m1 = 9'd95;
      2'd2:    ncbps_m1 = 9'd191;
      default: ncbps_m1 = 9'd287;
    endcase
  endfunction

  // The two permutation steps collapse to k = 16*(i mod d) + floor(i/d), where d = NCBPS/16.
  function automatic logic [8:0] perm_addr(input logic [8:0] j, input logic [1:0] m);
    logic [8:0] i, jd, t;
    i  = j;
    jd = '0;
    t  = '0;
    case (m)
      2'd0: perm_addr = ((j % 9'd3) << 4) + j / 9'd3;
      2'd1: perm_addr = ((j % 9'd6) << 4) + j / 9'd6;
      2'd2: begin
        jd = j / 9'd12;
        i  = {j[8:1], j[0] ^ jd[0]};
        perm_addr = ((i % 9'd12) << 4) + i / 9'd12;
      end
      default: begin
        jd = j / 9'd18;
        t  = j / 9'd3;
        i  = t * 9'd3 + (j + jd) % 9'd3;
        perm_addr = ((i % 9'd18) << 4) + i / 9'd18;
      end
    endcase
  endfunction

  logic [MAX_NCBPS-1:0] bank_q [2];

  logic [8:0] wr_j_q, wr_j_d;
  logic       wr_bank_q, wr_bank_d;
  logic [1:0] wr_mode_q, wr_mode_d;
  logic       rd_active_q, rd_active_d;
  logic [8:0] rd_k_q, rd_k_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] rd_mode_q, rd_mode_d;
  logic       pend_q, pend_d;
  logic       pend_bank_q, pend_bank_d;
  logic [1:0] pend_mode_q, pend_mode_d;

  logic [1:0] wr_mode_eff;
  logic [8:0] wr_addr;
  logic       wr_last;
  logic       rd_last;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    wr_j_d      = wr_j_q;
    wr_bank_d   = wr_bank_q;
    wr_mode_d   = wr_mode_q;
    rd_active_d = rd_active_q;
    rd_k_d      = rd_k_q;
    rd_bank_d   = rd_bank_q;
    rd_mode_d   = rd_mode_q;
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    pend_mode_d = pend_mode_q;

    // Mode is latched on the first valid bit of a symbol and frozen until the symbol ends.
    wr_mode_eff = (wr_j_q == 9'd0) ? mode : wr_mode_q;
    wr_addr     = perm_addr(wr_j_q, wr_mode_eff);
    wr_last     = inputValid && (wr_j_q == ncbps_m1(wr_mode_eff));
    rd_last     = rd_active_q && (rd_k_q == ncbps_m1(rd_mode_q));

    if (inputValid) begin
      wr_mode_d = wr_mode_eff;
      if (wr_last) begin
        wr_j_d    = 9'd0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_j_d = wr_j_q + 9'd1;
      end
    end

    if (!rd_active_q || rd_last) begin
      rd_k_d = 9'd0;
      if (pend_q) begin
        rd_active_d = 1'b1;
        rd_bank_d   = pend_bank_q;
        rd_mode_d   = pend_mode_q;
        pend_d      = wr_last;
        pend_bank_d = wr_bank_q;
        pend_mode_d = wr_mode_eff;
      end else if (wr_last) begin
        rd_active_d = 1'b1;
        rd_bank_d   = wr_bank_q;
        rd_mode_d   = wr_mode_eff;
      end else begin
        rd_active_d = 1'b0;
      end
    end else begin
      rd_k_d = rd_k_q + 9'd1;
      if (wr_last) begin
        pend_d      = 1'b1;
        pend_bank_d = wr_bank_q;
        pend_mode_d = wr_mode_eff;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      wr_j_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_mode_q   <= '0;
      rd_active_q <= 1'b0;
      rd_k_q      <= '0;
      rd_bank_q   <= 1'b0;
      rd_mode_q   <= '0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      pend_mode_q <= '0;
    end else begin
      wr_j_q      <= wr_j_d;
      wr_bank_q   <= wr_bank_d;
      wr_mode_q   <= wr_mode_d;
      rd_active_q <= rd_active_d;
      rd_k_q      <= rd_k_d;
      rd_bank_q   <= rd_bank_d;
      rd_mode_q   <= rd_mode_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      pend_mode_q <= pend_mode_d;
    end
  end

  // NOTE: the symbol banks are deliberately not reset; stale contents are never read out.
  always_ff @(posedge clock) begin
    if (inputValid) bank_q[wr_bank_q][wr_addr] <= inputData;
  end

  assign outputValid = rd_active_q;
  assign outputData  = rd_active_q & bank_q[rd_bank_q][rd_k_q];
`ifdef DEINTERLEAVER_SYMBOL_END_EN
  assign symbolEnd   = rd_last;
`endif

endmodule

// File: tb/tb_deinterleaver.sv
// Self-checking bench for deinterleaver: formula-level model, per-cycle compare, directed symbols.
module tb_deinterleaver;

  logic       clock = 1'b0;
  logic       reset;
  logic       inputData;
  logic       inputValid;
  logic [1:0] mode;
  logic       outputData;
  logic       outputValid;
`ifdef DEINTERLEAVER_SYMBOL_END_EN
  logic       symbolEnd;
`endif

  always #5 clock = ~clock;

  deinterleaver dut (
    .clock       (clock),
    .reset       (reset),
    .inputData   (inputData),
    .inputValid  (inputValid),
    .mode        (mode),
    .outputData  (outputData),
`ifdef DEINTERLEAVER_SYMBOL_END_EN
    .symbolEnd   (symbolEnd),
`endif
    .outputValid (outputValid)
  );

  typedef struct packed {
    logic d;
    logic e;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;
  logic obs[$];
  logic sym_bits[288];
  logic saved[288];
  int   total = 0;
  int   bad = 0;
  int   run = 0;
  int   last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int ncbps(input int m);
    case (m)
      0:       return 48;
      1:       return 96;
      2:       return 192;
      default: return 288;
    endcase
  endfunction

  // Literal standard formula: input index j -> output position k.
  function automatic int model_k(input int m, input int j);
    int n, s, i;
    int nbpsc[4] = '{1, 2, 4, 6};
    n = ncbps(m);
    s = nbpsc[m] / 2;
    if (s < 1) s = 1;
    i = s * (j / s) + (j + (16 * j) / n) % s;
    return 16 * i - (n - 1) * ((16 * i) / n);
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      if (outputValid) begin
        run++;
        obs.push_back(outputData);
        if (exp_q.size() == 0) begin
          check("valid_without_expect", 32'(exp_q.size()), 32'd1);
        end else begin
          e_cur = exp_q.pop_front();
          check("out_data", 32'(outputData), 32'(e_cur.d));
`ifdef DEINTERLEAVER_SYMBOL_END_EN
          check("symbol_end", 32'(symbolEnd), 32'(e_cur.e));
`endif
        end
      end else begin
        if (run > 0) last_run = run;
        run = 0;
        check("idle_data_zero", 32'(outputData), 32'd0);
`ifdef DEINTERLEAVER_SYMBOL_END_EN
        check("idle_symbol_end", 32'(symbolEnd), 32'd0);
`endif
      end
    end else begin
      run = 0;
    end
  end

  task automatic send_symbol(input int m, input int chg_at, input int chg_to,
                             input bit gaps, input bit check_lat);
    int   n;
    logic outb[288];
    exp_t x;
    n = ncbps(m);
    for (int j = 0; j < n; j++) outb[model_k(m, j)] = sym_bits[j];
    for (int j = 0; j < n; j++) begin
      @(negedge clock);
      if (j == 0) mode = 2'(m);
      if (j == chg_at) mode = 2'(chg_to);
      inputValid = 1'b1;
      inputData  = sym_bits[j];
      if (j == n - 1) begin
        if (check_lat) check("valid_low_before_last", 32'(outputValid), 32'd0);
        for (int k = 0; k < n; k++) begin
          x.d = outb[k];
          x.e = (k == n - 1);
          exp_q.push_back(x);
        end
        if (check_lat) begin
          @(posedge clock);
          #1;
          check("valid_one_clk_after_last", 32'(outputValid), 32'd1);
        end
      end else if (gaps) begin
        @(negedge clock);
        inputValid = 1'b0;
        inputData  = ~sym_bits[j];
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clock);
    inputValid = 1'b0;
    inputData  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0 && !outputValid) break;
    end
    check("drain_expected_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_bits();
    for (int j = 0; j < 288; j++) sym_bits[j] = 1'b0;
  endtask

  task automatic rand_bits();
    for (int j = 0; j < 288; j++) sym_bits[j] = 1'($urandom_range(0, 1));
  endtask

  function automatic int one_pos(input int base, input int n);
    for (int i = 0; i < n; i++) if (obs[base + i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int one_cnt(input int base, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (obs[base + i] === 1'b1) c++;
    return c;
  endfunction

  int base;
  int diffs;

  initial begin
    reset      = 1'b0;
    inputValid = 1'b0;
    inputData  = 1'b0;
    mode       = 2'd0;
    #12;
    check("reset_valid", 32'(outputValid), 32'd0);
    check("reset_data", 32'(outputData), 32'd0);

    check("pin_m3_j1", 32'(model_k(3, 1)), 32'd16);
    check("pin_m3_j18", 32'(model_k(3, 18)), 32'd17);
    check("pin_m3_j3", 32'(model_k(3, 3)), 32'd48);
    check("pin_m0_j6", 32'(model_k(0, 6)), 32'd2);
    check("pin_m0_j1", 32'(model_k(0, 1)), 32'd16);
    check("pin_m1_j3", 32'(model_k(1, 3)), 32'd48);

    @(negedge clock);
    reset = 1'b1;

    // Mode 3: two back-to-back one-hot symbols.
    base = obs.size();
    clear_bits();
    sym_bits[1] = 1'b1;
    send_symbol(3, -1, 0, 1'b0, 1'b1);
    send_symbol(3, -1, 0, 1'b0, 1'b0);
    go_idle();
    wait_drain();
    check("m3_run_len", 32'(last_run), 32'd576);
    check("m3_s0_pos", 32'(one_pos(base, 288)), 32'd16);
    check("m3_s0_cnt", 32'(one_cnt(base, 288)), 32'd1);
    check("m3_s1_pos", 32'(one_pos(base + 288, 288)), 32'd16);
    check("m3_s1_cnt", 32'(one_cnt(base + 288, 288)), 32'd1);

    // Mode 3: ones at j=18 and j=3.
    base = obs.size();
    clear_bits();
    sym_bits[18] = 1'b1;
    sym_bits[3]  = 1'b1;
    send_symbol(3, -1, 0, 1'b0, 1'b0);
    go_idle();
    wait_drain();
    check("m3_j18_k17", 32'(obs[base + 17]), 32'd1);
    check("m3_j3_k48", 32'(obs[base + 48]), 32'd1);
    check("m3_two_ones", 32'(one_cnt(base, 288)), 32'd2);

    // Mode 0: j=6 -> 2, then j=1 -> 16.
    base = obs.size();
    clear_bits();
    sym_bits[6] = 1'b1;
    send_symbol(0, -1, 0, 1'b0, 1'b1);
    clear_bits();
    sym_bits[1] = 1'b1;
    send_symbol(0, -1, 0, 1'b0, 1'b0);
    go_idle();
    wait_drain();
    check("m0_j6_pos", 32'(one_pos(base, 48)), 32'd2);
    check("m0_j6_cnt", 32'(one_cnt(base, 48)), 32'd1);
    check("m0_j1_pos", 32'(one_pos(base + 48, 48)), 32'd16);
    check("m0_j1_cnt", 32'(one_cnt(base + 48, 48)), 32'd1);

    // Mode 1: j=3 -> 48.
    base = obs.size();
    clear_bits();
    sym_bits[3] = 1'b1;
    send_symbol(1, -1, 0, 1'b0, 1'b1);
    go_idle();
    wait_drain();
    check("m1_j3_pos", 32'(one_pos(base, 96)), 32'd48);
    check("m1_len", 32'(obs.size() - base), 32'd96);

    // Mode 2: random symbol against the model.
    base = obs.size();
    rand_bits();
    send_symbol(2, -1, 0, 1'b0, 1'b1);
    go_idle();
    wait_drain();
    check("m2_len", 32'(obs.size() - base), 32'd192);

    // Mode 3: continuous vs. valid toggled every other cycle.
    base = obs.size();
    rand_bits();
    send_symbol(3, -1, 0, 1'b0, 1'b1);
    go_idle();
    wait_drain();
    for (int i = 0; i < 288; i++) saved[i] = obs[base + i];
    base = obs.size();
    send_symbol(3, -1, 0, 1'b1, 1'b1);
    go_idle();
    wait_drain();
    check("toggle_len", 32'(obs.size() - base), 32'd288);
    diffs = 0;
    for (int i = 0; i < 288; i++) if (obs[base + i] !== saved[i]) diffs++;
    check("toggle_same_as_cont", 32'(diffs), 32'd0);

    // Mode change 3 -> 0 at j=100, then a mode 0 symbol.
    base = obs.size();
    rand_bits();
    send_symbol(3, 100, 0, 1'b0, 1'b1);
    rand_bits();
    send_symbol(0, -1, 0, 1'b0, 1'b0);
    go_idle();
    wait_drain();
    check("modechg_len", 32'(obs.size() - base), 32'd336);
    check("modechg_run", 32'(last_run), 32'd336);

    // Reset during output bit 50.
    base = obs.size();
    rand_bits();
    send_symbol(3, -1, 0, 1'b0, 1'b0);
    go_idle();
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      #1;
      if (obs.size() >= base + 50) break;
    end
    check("reached_bit50", 32'(obs.size() - base), 32'd50);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_valid", 32'(outputValid), 32'd0);
    check("async_reset_data", 32'(outputData), 32'd0);
`ifdef DEINTERLEAVER_SYMBOL_END_EN
    check("async_reset_symend", 32'(symbolEnd), 32'd0);
`endif
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (320) @(negedge clock);
    #1;
    check("no_out_after_reset", 32'(obs.size() - base), 32'd50);

    // Fresh symbol after reset.
    base = obs.size();
    clear_bits();
    sym_bits[3] = 1'b1;
    send_symbol(1, -1, 0, 1'b0, 1'b1);
    go_idle();
    wait_drain();
    check("post_reset_m1_pos", 32'(one_pos(base, 96)), 32'd48);
    check("post_reset_m1_len", 32'(obs.size() - base), 32'd96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deinterleaver.md
Name: deinterleaver

Overview:
- Receive-side bit deinterleaver for the 802.11a PHY. Sits between the soft/hard demapper and the Viterbi decoder.
- Accepts one coded bit per clock, collects a full OFDM symbol (NCBPS bits), and emits the bits serially in de-permuted order.
- Undoes the two-step 802.11a interleaver permutation.

Parameters:
- MAX_NCBPS, 288, bits per symbol buffer bank (64-QAM worst case); fixed, not to be overridden below 288.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- inputData  input  1  coded bit from demapper
- inputValid  input  1  inputData is valid this cycle
- mode  input  2  modulation: 0=BPSK, 1=QPSK, 2=16-QAM, 3=64-QAM
- outputData  output  1  deinterleaved bit
- outputValid  output  1  outputData is valid this cycle

Behaviour:
- Mode table (NCBPS/NBPSC): 0→48/1, 1→96/2, 2→192/4, 3→288/6. s = max(NBPSC/2, 1), i.e. 1, 1, 2, 3.
- Permutation: input bit index j (0..NCBPS-1 within symbol) goes to output position k.
  - i = s*floor(j/s) + (j + floor(16*j/NCBPS)) mod s
  - k = 16*i − (NCBPS−1)*floor(16*i/NCBPS)
  - Computed with an incremental counter or LUT/arithmetic; no multi-cycle stall allowed.
- Storage: two MAX_NCBPS-bit banks (ping-pong).
  - Write side stores bit j at address k of the write bank on each inputValid cycle.
  - When j reaches NCBPS−1, the bank is handed to the read side, the banks swap, and j returns to 0.
- Mode is sampled when j==0 and the first valid bit of a symbol arrives. It is held for the whole symbol, both write and read. A mode change mid-symbol is ignored until the next symbol.
- Read side:
  - On the cycle after the last bit of a symbol is written, outputValid=1 with outputData = bank[0].
  - Then bank[1]..bank[NCBPS−1] follow on consecutive clocks, one per clock, no gaps.
  - outputValid then drops unless the next bank is already complete.
- Latency: outputValid rises exactly 1 clock after the clock edge that registers input bit NCBPS−1.
- Throughput: continuous inputValid=1 yields continuous output with no gaps after the first symbol; reading symbol n overlaps writing symbol n+1.
- inputValid=0 mid-symbol: the write counter holds and bits are kept. Resuming continues at the same j; there is no timeout.
- An incomplete trailing symbol is never output.
- Reset (reset=0, any time, async): outputValid=0, outputData=0, write/read counters=0, bank select=0, read-active=0. Buffer contents are don't-care. Any symbol in progress is discarded.
- outputData is 0 whenever outputValid=0.

Optional Feature:
- Macro DEINTERLEAVER_SYMBOL_END_EN.
- Defined: adds output port symbolEnd (1 bit). It is high for exactly the cycle carrying output bit NCBPS−1 (with outputValid=1), and 0 in reset and otherwise.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Mode 3, 576 continuous valid bits (two symbols), each a one-hot at j=1 → outputValid high for 576 consecutive cycles, starting 1 clock after input bit 287. Symbol 0 output is 1 only at position 16, likewise symbol 1; input at j=18 maps to k=17, input at j=3 to k=48.
- Mode 0, one symbol with a 1 at j=6 only → 48 output bits, single 1 at position 2. With a 1 at j=1 only → single 1 at position 16.
- Mode 1, 1 at j=3 → single 1 at output position 48 of 96. Mode 2, random 192 bits → matches golden model of the formula bit-exactly.
- inputValid toggled 0/1 every other cycle in mode 3 → identical output sequence to the continuous case; outputValid stays 0 until bit 287 is written.
- Mode changed from 3 to 0 at j=100 → the current symbol still completes as 288 bits; the next symbol uses 48.
- reset pulled low at output bit 50 of a symbol → outputValid=0 immediately (asynchronously). After release, nothing is output until a new full symbol is received.
